dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the CPU load/store interface (addr, MemOp, wdata, wen).
//   Owns a word-organised data SRAM: byte-lane stores, sign/zero-extending loads.
//   Uses a valid/ready request and a valid/ready response with programmable latency.
//   Replaces the combinational data-memory model for the multi-cycle core.
// PARAMETERS
//   DEPTH_WORDS  1024           number of 32-bit words in the array (power of 2)
//   BASE_ADDR    32'h8000_0000  byte address of word 0
//   LATENCY      1              cycles from request accept to rsp_valid (>=1)
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous reset, active-high
//   req_valid   in   1   request present
//   req_ready   out  1   request accepted when req_valid & req_ready
//   req_addr    in   32  byte address
//   req_memop   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores
//   req_wen     in   1   1 = store, 0 = load
//   req_wdata   in   32  store data, right-aligned
//   rsp_valid   out  1   response present; held until rsp_ready
//   rsp_ready   in   1   consumer takes the response
//   rsp_rdata   out  32  extended load data; 0 for stores and errors
//   rsp_err     out  1   access faulted; no array side effect
// BEHAVIOUR
//   FSM states: IDLE, WAIT, RESP. Reset: IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   The array is not reset. Its contents persist through rst.
//   req_ready = (state==IDLE) | (state==RESP & rsp_ready).
//   Accept: latch addr/memop/wen/wdata. Load cnt = LATENCY-1.
//     If cnt==0, go to RESP next cycle. Otherwise go to WAIT.
//   WAIT: cnt decrements each cycle. When cnt==1, go to RESP next cycle.
//   RESP entry edge: the access executes exactly once.
//     Store: write with byte mask. rsp_rdata is registered on the same edge.
//   RESP: outputs stay stable while rsp_valid & !rsp_ready.
//     On handshake: accept the new request if present (back-to-back, no bubble), else go to IDLE.
//   Index = (addr - BASE_ADDR) >> 2, 32-bit unsigned arithmetic.
//     If index >= DEPTH_WORDS: rsp_err=1, no write.
//   Invalid memop (011, 110, 111) on a load or store: rsp_err=1, no write.
//   Byte lane = addr[1:0]. Half lane = addr[1].
//     Store masks: B 0001<<addr[1:0], H 0011<<(2*addr[1]), W 1111.
//     Store data is replicated to the selected lanes.
//   Load extend: B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes through.
//   Back-to-back load after a store to the same word returns the new data.
//   rst asserted mid-transaction: the pending access is dropped, and any write not yet at RESP entry never occurs.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     H/HU/SH with addr[0]=1 -> rsp_err=1, rdata 0, no write.
//     W/SW with addr[1:0]!=0 -> rsp_err=1, rdata 0, no write.
//   Undefined: H accesses use addr[1] only (addr[0] ignored).
//     W accesses ignore addr[1:0] (aligned down). No misalignment error.
// STRUCTURE
//   Package dmem_pkg:
//     MemOp localparams (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU).
//     FSM state enum.
//     Function store_mask(memop, addr_lo) -> 4-bit mask.
//   Sub-module dmem_load_ext: combinational (word, memop, addr_lo) -> extended 32-bit data.
//     Shared later with the cache refill path.
//   Top holds the FSM, the latency counter, the request latch and the array.
// TESTING
//   1. LATENCY=1: SW 0x8000_0000 <= 0xDEADBEEF, then LW from the same address.
//      -> rdata 0xDEADBEEF; each rsp_valid exactly 1 cycle after accept.
//   2. After test 1: LB @+3 -> 0xFFFFFFDE; LBU @+3 -> 0x000000DE; LH @+0 -> 0xFFFFBEEF; LHU @+2 -> 0x0000DEAD.
//   3. SB 0x12 @+1 over 0xDEADBEEF -> LW returns 0xDEAD12EF.
//      SH 0x5678 @+2 -> LW returns 0x567812EF.
//   4. LATENCY=3: stall rsp_ready low for 4 cycles.
//      -> rsp_valid 3 cycles after accept; rdata/err stable; req_ready=0 throughout.
//   5. Out of range: LW 0x8000_1000 (DEPTH 1024) -> err=1, rdata 0.
//      Invalid memop 3'b111 store -> err=1; a later LW of the target word is unchanged.
//   6. rst pulsed during WAIT of a SW -> rsp_valid=0, FSM in IDLE, the word is not updated.
//      Under MISALIGN_TRAP_EN: LW @+2 -> err=1. Without it: LW @+2 returns the word at +0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MemOp encodings, FSM state type and lane helpers for the data memory.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latched request as seen on the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  memop;
    logic        wen;
    logic [31:0] wdata;
  } req_t;

  function automatic logic memop_valid(input logic [2:0] memop);
    case (memop)
      MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU: memop_valid = 1'b1;
      default:                             memop_valid = 1'b0;
    endcase
  endfunction

  // Byte-lane write mask; halves use addr[1] only, words ignore the low bits.
  function automatic logic [3:0] store_mask(input logic [2:0] memop, input logic [1:0] addr_lo);
    case (memop[1:0])
      2'b00:   store_mask = 4'b0001 << addr_lo;
      2'b01:   store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Right-aligned store data replicated across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [2:0] memop, input logic [31:0] wdata);
    case (memop[1:0])
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between a load/store master and the data memory.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response channels.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_memop;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_memop, req_wen, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_memop, req_wen, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: selects the addressed byte/half of a memory word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  memop,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension by MemOp; unknown ops return zero.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    case (memop)
      MOP_B:   data = {{24{byte_sel[7]}}, byte_sel};
      MOP_BU:  data = {24'h0, byte_sel};
      MOP_H:   data = {{16{half_sel[15]}}, half_sel};
      MOP_HU:  data = {16'h0, half_sel};
      MOP_W:   data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data SRAM behind a valid/ready load/store port (define MISALIGN_TRAP_EN to fault misaligned H/W).
// Latency: LATENCY cycles from request accept to rsp_valid; the access executes on the RESP entry edge.
// Backpressure: response held while rsp_ready is low; req_ready only in IDLE or on a RESP handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input logic         clk,
  input logic         rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          req_q;
  req_t          req_in;
  req_t          ex_req;
  logic          accept;
  logic          exec_now;
  logic [31:0]   idx_full;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misalign;
  logic          ex_err;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   rdata_next;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          wr_en;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req_in = '{addr: bus.req_addr, memop: bus.req_memop, wen: bus.req_wen, wdata: bus.req_wdata};

  assign bus.req_ready = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  // With LATENCY==1 the access runs on the accept edge itself, straight off the bus;
  // otherwise it runs from the latch on the last WAIT edge.
  assign exec_now = accept ? (LATENCY == 1) : ((state == WAIT) && (cnt == CW'(1)));
  assign ex_req   = accept ? req_in : req_q;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign idx_full = (ex_req.addr - BASE_ADDR) >> 2;
  assign idx      = idx_full[AW-1:0];
  assign in_range = idx_full < 32'(DEPTH_WORDS);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((ex_req.memop[1:0] == 2'b01) & ex_req.addr[0]) |
                    ((ex_req.memop == MOP_W) & (ex_req.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign ex_err = ~in_range | ~memop_valid(ex_req.memop) | misalign;

  assign rd_word = mem[idx];

  dmem_load_ext u_load_ext (
    .word    (rd_word),
    .memop   (ex_req.memop),
    .addr_lo (ex_req.addr[1:0]),
    .data    (ld_data)
  );

  assign rdata_next = (ex_err | ex_req.wen) ? 32'h0 : ld_data;
  assign wr_mask    = store_mask(ex_req.memop, ex_req.addr[1:0]);
  assign wr_data    = store_data(ex_req.memop, ex_req.wdata);
  // A write that has not reached RESP entry when rst asserts must never land.
  assign wr_en      = exec_now & ex_req.wen & ~ex_err & ~rst;

  // Byte-masked array write; the array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Control FSM: request latch, latency countdown and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      req_q <= req_in;
      if (exec_now) begin
        state       <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_next;
        rsp_err_q   <= ex_err;
      end else begin
        state       <= WAIT;
        cnt         <= CNT_INIT;
        rsp_valid_q <= 1'b0;
      end
    end else begin
      case (state)
        WAIT: begin
          if (exec_now) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_next;
            rsp_err_q   <= ex_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors against a LATENCY=1 and a LATENCY=3 instance.
// Latency: checks accept-to-rsp_valid distance per instance.
// Backpressure: holds rsp_ready low to exercise the stall and req_ready behaviour.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  logic        sel;            // 0 drives the LATENCY=1 instance, 1 the LATENCY=3 one
  logic        t_valid, t_wen, t_rsp_ready;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_memop;

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder_if if1();
  dmem_responder_if if3();

  assign if1.req_valid = t_valid & ~sel;
  assign if1.req_addr  = t_addr;
  assign if1.req_memop = t_memop;
  assign if1.req_wen   = t_wen;
  assign if1.req_wdata = t_wdata;
  assign if1.rsp_ready = t_rsp_ready & ~sel;

  assign if3.req_valid = t_valid & sel;
  assign if3.req_addr  = t_addr;
  assign if3.req_memop = t_memop;
  assign if3.req_wen   = t_wen;
  assign if3.req_wdata = t_wdata;
  assign if3.rsp_ready = t_rsp_ready & sel;

  assign o_req_ready = sel ? if3.req_ready : if1.req_ready;
  assign o_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  assign o_rsp_rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;
  assign o_rsp_err   = sel ? if3.rsp_err   : if1.rsp_err;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.slave)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response; leaves rsp_ready low with the response pending.
  task automatic xfer(input logic [31:0] addr, input logic [2:0] mop, input logic wen,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int guard;
    @(negedge clk);
    t_addr = addr; t_memop = mop; t_wen = wen; t_wdata = wd;
    t_valid = 1'b1; t_rsp_ready = 1'b0;
    #1;
    guard = 0;
    while (o_req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (o_req_ready !== 1'b1) check("accept_timeout", {31'b0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_rsp_valid !== 1'b1 && lat < 20);
    if (o_rsp_valid !== 1'b1) check("rsp_timeout", {31'b0, o_rsp_valid}, 32'd1);
    rd = o_rsp_rdata;
    er = o_rsp_err;
  endtask

  task automatic release_rsp();
    t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [31:0] addr, input logic [2:0] mop,
                    input logic wen, input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(addr, mop, wen, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    check({tag, "_lat"}, lat, exp_lat);
    release_rsp();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst1 = 1'b1; rst3 = 1'b1; sel = 1'b0;
    t_valid = 1'b0; t_wen = 1'b0; t_rsp_ready = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0; t_memop = 3'b000;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk); #1;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
      check("rst_rsp_err",   {31'b0, o_rsp_err}, 32'd0);
    end
    sel = 1'b0;

    // Word store then load, LATENCY=1
    op("sw_base",  32'h8000_0000, MOP_W,  1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0, 1);
    op("lw_base",  32'h8000_0000, MOP_W,  1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1);

    // Sub-word loads with extension
    op("lb_3",     32'h8000_0003, MOP_B,  1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0, 1);
    op("lbu_3",    32'h8000_0003, MOP_BU, 1'b0, 32'h0, 32'h0000_00DE, 1'b0, 1);
    op("lh_0",     32'h8000_0000, MOP_H,  1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0, 1);
    op("lhu_2",    32'h8000_0002, MOP_HU, 1'b0, 32'h0, 32'h0000_DEAD, 1'b0, 1);

    // Byte and half stores merge into the word
    op("sb_1",     32'h8000_0001, MOP_B,  1'b1, 32'h0000_0012, 32'h0,         1'b0, 1);
    op("lw_sb",    32'h8000_0000, MOP_W,  1'b0, 32'h0,         32'hDEAD_12EF, 1'b0, 1);
    op("sh_2",     32'h8000_0002, MOP_H,  1'b1, 32'h0000_5678, 32'h0,         1'b0, 1);
    op("lw_sh",    32'h8000_0000, MOP_W,  1'b0, 32'h0,         32'h5678_12EF, 1'b0, 1);

    // Range and memop faults
    op("lw_oob",   32'h8000_1000, MOP_W,  1'b0, 32'h0,         32'h0,         1'b1, 1);
    op("lw_below", 32'h7FFF_FFFC, MOP_W,  1'b0, 32'h0,         32'h0,         1'b1, 1);
    op("st_bad",   32'h8000_0000, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 1);
    op("lw_nochg", 32'h8000_0000, MOP_W,  1'b0, 32'h0,         32'h5678_12EF, 1'b0, 1);

    // LATENCY=3 instance
    sel = 1'b1;
    op("sw3",      32'h8000_0010, MOP_W,  1'b1, 32'h1122_3344, 32'h0,         1'b0, 3);

    // Stall: response held with rsp_ready low, a new request waiting
    xfer(32'h8000_0010, MOP_W, 1'b0, 32'h0, rd, er, lat);
    check("stall_lat",   lat, 32'd3);
    check("stall_rdata", rd, 32'h1122_3344);
    t_valid = 1'b1; t_addr = 32'h8000_0020; t_memop = MOP_W; t_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("stall_valid",     {31'b0, o_rsp_valid}, 32'd1);
      check("stall_rdata_hld", o_rsp_rdata, 32'h1122_3344);
      check("stall_err_hld",   {31'b0, o_rsp_err}, 32'd0);
      check("stall_req_ready", {31'b0, o_req_ready}, 32'd0);
    end
    t_valid = 1'b0;
    release_rsp();

    // Reset during WAIT of a store drops it
    @(negedge clk);
    t_addr = 32'h8000_0010; t_memop = MOP_W; t_wen = 1'b1; t_wdata = 32'hAAAA_AAAA;
    t_valid = 1'b1;
    #1;
    check("rstw_ready", {31'b0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check("rstw_in_wait", {31'b0, o_req_ready}, 32'd0);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("rstw_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rstw_idle",  {31'b0, o_req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rstw_quiet", {31'b0, o_rsp_valid}, 32'd0);
    op("lw_rstw", 32'h8000_0010, MOP_W, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 3);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    op("lw_mis", 32'h8000_0012, MOP_W, 1'b0, 32'h0, 32'h0, 1'b1, 3);
    op("lh_mis", 32'h8000_0011, MOP_H, 1'b0, 32'h0, 32'h0, 1'b1, 3);
`else
    op("lw_mis", 32'h8000_0012, MOP_W, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 3);
    op("lh_mis", 32'h8000_0011, MOP_H, 1'b0, 32'h0, 32'h0000_3344, 1'b0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
